// File: rtl/ts_pkg.sv
// ts_sched shared definitions: FSM encoding, queue geometry, counter width.
// Also provides the strict-priority pick and one-hot helpers.
package ts_pkg;

    localparam int NUM_Q    = 4;
    localparam int QID_W    = 2;
    localparam int MD_W_DEF = 32;
    localparam int CNT_W    = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_OUT  = 3'd3,
        S_WAIT = 3'd4
    } ts_state_t;

    // Lowest set index wins: Q0 is the highest priority.
    function automatic logic [QID_W-1:0] prio_sel(
        input logic [NUM_Q-1:0] mask
    );
        logic [QID_W-1:0] r;
        r = '0;
        for (int i = NUM_Q - 1; i >= 0; i--) begin
            if (mask[i]) r = QID_W'(i);
        end
        return r;
    endfunction

    function automatic logic [NUM_Q-1:0] qid_onehot(
        input logic [QID_W-1:0] qid
    );
        logic [NUM_Q-1:0] r;
        r = '0;
        r[qid] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/ts_stat.sv
// Per-queue forwarded-packet counters for ts_sched.
// Counts non-discarded metadata strobes per source queue; wraps naturally.
module ts_stat
    import ts_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   md_wr,
    input  logic [QID_W-1:0]       md_qid,
    input  logic                   md_discard,
    output logic [NUM_Q*CNT_W-1:0] q_cnt
);

    logic [NUM_Q-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (md_wr && !md_discard) begin
            cnt_q[md_qid] <= cnt_q[md_qid] + CNT_W'(1);
        end
    end

    assign q_cnt = cnt_q;

endmodule

// File: rtl/ts_sched.sv
// Strict-priority transmit scheduler: gate control -> queue FIFO -> EBM.
// Define TS_STAT_EN to add the per-queue counter bank and out_ts_q_cnt.
module ts_sched
    import ts_pkg::*;
#(
    parameter string PLATFORM = "xilinx",
    parameter int    MD_W     = MD_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_Q-1:0]       in_ts_schedule_valid,
    output logic [NUM_Q-1:0]       out_ts_q_rden,
    output logic                   out_ts_q2_rden,
    input  logic [NUM_Q*MD_W-1:0]  in_ts_q_md,
    input  logic                   in_ts_bandwidth_discard,
    output logic [MD_W-1:0]        out_ts_md,
    output logic [QID_W-1:0]       out_ts_md_qid,
    output logic                   out_ts_md_discard,
    output logic                   out_ts_md_wr,
    input  logic                   in_ts_pkt_done,
`ifdef TS_STAT_EN
    output logic [NUM_Q*CNT_W-1:0] out_ts_q_cnt,
`endif
    output logic                   out_ts_busy
);

    // Vendor hook only; the scheduler behaves identically on every target.
    if (PLATFORM == "xilinx") begin : g_plat_xilinx
    end else begin : g_plat_other
    end

    ts_state_t         state_q, state_d;
    logic [QID_W-1:0]  sel_q, sel_d;
    logic [NUM_Q-1:0]  rden_q, rden_d;
    logic [MD_W-1:0]   md_q, md_d;
    logic [QID_W-1:0]  qid_q, qid_d;
    logic              disc_q, disc_d;
    logic              wr_q, wr_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rden_d  = '0;
        md_d    = md_q;
        qid_d   = qid_q;
        disc_d  = disc_q;
        wr_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|in_ts_schedule_valid) begin
                    sel_d   = prio_sel(in_ts_schedule_valid);
                    rden_d  = qid_onehot(sel_d);
                    state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                md_d    = in_ts_q_md[int'(sel_q)*MD_W +: MD_W];
                qid_d   = sel_q;
                disc_d  = in_ts_bandwidth_discard
                        & (sel_q == QID_W'(2));
                wr_d    = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (in_ts_pkt_done) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Busy is registered, so it tracks the state being entered.
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            rden_q  <= '0;
            md_q    <= '0;
            qid_q   <= '0;
            disc_q  <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rden_q  <= rden_d;
            md_q    <= md_d;
            qid_q   <= qid_d;
            disc_q  <= disc_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
        end
    end

    assign out_ts_q_rden     = rden_q;
    assign out_ts_q2_rden    = rden_q[2];
    assign out_ts_md         = md_q;
    assign out_ts_md_qid     = qid_q;
    assign out_ts_md_discard = disc_q;
    assign out_ts_md_wr      = wr_q;
    assign out_ts_busy       = busy_q;

`ifdef TS_STAT_EN
    ts_stat u_stat (
        .clk        (clk),
        .rst        (rst),
        .md_wr      (wr_q),
        .md_qid     (qid_q),
        .md_discard (disc_q),
        .q_cnt      (out_ts_q_cnt)
    );
`endif

endmodule

// File: tb/tb_ts_sched.sv
// Self-checking bench for ts_sched with a transaction-level reference model.
// Build with +define+TS_STAT_EN to also check the counter bank.
module tb_ts_sched;
    import ts_pkg::*;

    localparam int MDW = 32;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [3:0]             in_ts_schedule_valid = '0;
    logic [3:0]             out_ts_q_rden;
    logic                   out_ts_q2_rden;
    logic [4*MDW-1:0]       in_ts_q_md = '0;
    logic                   in_ts_bandwidth_discard = 1'b0;
    logic [MDW-1:0]         out_ts_md;
    logic [1:0]             out_ts_md_qid;
    logic                   out_ts_md_discard;
    logic                   out_ts_md_wr;
    logic                   in_ts_pkt_done = 1'b0;
    logic                   out_ts_busy;
`ifdef TS_STAT_EN
    logic [127:0]           out_ts_q_cnt;
`endif

    int total = 0;
    int bad = 0;
    int rden_pulses = 0;
    int wr_pulses = 0;
    logic [31:0] mcnt [4];

    ts_sched #(.PLATFORM("xilinx"), .MD_W(MDW)) u_dut (
        .clk                     (clk),
        .rst                     (rst),
        .in_ts_schedule_valid    (in_ts_schedule_valid),
        .out_ts_q_rden           (out_ts_q_rden),
        .out_ts_q2_rden          (out_ts_q2_rden),
        .in_ts_q_md              (in_ts_q_md),
        .in_ts_bandwidth_discard (in_ts_bandwidth_discard),
        .out_ts_md               (out_ts_md),
        .out_ts_md_qid           (out_ts_md_qid),
        .out_ts_md_discard       (out_ts_md_discard),
        .out_ts_md_wr            (out_ts_md_wr),
        .in_ts_pkt_done          (in_ts_pkt_done),
`ifdef TS_STAT_EN
        .out_ts_q_cnt            (out_ts_q_cnt),
`endif
        .out_ts_busy             (out_ts_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (|out_ts_q_rden) rden_pulses++;
        if (out_ts_md_wr) wr_pulses++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: strict priority means the first set bit counting from Q0.
    function automatic int ref_pick(input logic [3:0] mask);
        for (int i = 0; i < 4; i++) if (mask[i]) return i;
        return -1;
    endfunction

    task automatic run_pkt(
        input logic [3:0]       mask,
        input logic [3:0][31:0] md,
        input bit               disc,
        input int               dly,
        input bit               noise,
        input string            tag
    );
        int q;
        int r0;
        int w0;
        logic [3:0] erden;
        logic [31:0] emd;
        bit edisc;
        q = ref_pick(mask);
        erden = 4'(1 << q);
        emd = md[q];
        edisc = disc && (q == 2);
        r0 = rden_pulses;
        w0 = wr_pulses;
        in_ts_q_md = md;
        in_ts_schedule_valid = mask;
        tick;
        in_ts_schedule_valid = '0;
        total++;
        if (out_ts_q_rden !== erden || out_ts_q2_rden !== (q == 2)) begin
            bad++;
            $display("FAIL %s rden got=%b/%b want=%b", tag,
                     out_ts_q_rden, out_ts_q2_rden, erden);
        end
        total++;
        if (out_ts_busy !== 1'b1 || out_ts_md_wr !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_rd got busy=%b wr=%b want 1/0", tag,
                     out_ts_busy, out_ts_md_wr);
        end
        if (noise) in_ts_pkt_done = 1'b1;
        tick;
        in_ts_pkt_done = 1'b0;
        in_ts_bandwidth_discard = disc;
        if (noise) in_ts_schedule_valid = 4'($urandom_range(1, 15));
        total++;
        if (out_ts_q_rden !== 4'b0000) begin
            bad++;
            $display("FAIL %s rden_one_cycle got=%b want=0000", tag,
                     out_ts_q_rden);
        end
        tick;
        in_ts_bandwidth_discard = 1'b0;
        in_ts_schedule_valid = '0;
        total++;
        if (out_ts_md_wr !== 1'b1 || out_ts_md !== emd ||
            out_ts_md_qid !== 2'(q) || out_ts_md_discard !== edisc) begin
            bad++;
            $display("FAIL %s md_out got wr=%b md=%h qid=%0d d=%b want 1 %h %0d %b",
                     tag, out_ts_md_wr, out_ts_md, out_ts_md_qid,
                     out_ts_md_discard, emd, q, edisc);
        end
        tick;
        if (!edisc) mcnt[q] = mcnt[q] + 32'd1;
        total++;
        if (out_ts_md_wr !== 1'b0 || out_ts_md !== emd) begin
            bad++;
            $display("FAIL %s md_hold got wr=%b md=%h want 0 %h", tag,
                     out_ts_md_wr, out_ts_md, emd);
        end
        for (int k = 0; k < dly; k++) begin
            if (noise) in_ts_schedule_valid = 4'($urandom_range(1, 15));
            tick;
            total++;
            if (out_ts_busy !== 1'b1) begin
                bad++;
                $display("FAIL %s busy_wait got=%b want=1", tag, out_ts_busy);
            end
        end
        in_ts_schedule_valid = '0;
        in_ts_pkt_done = 1'b1;
        tick;
        in_ts_pkt_done = 1'b0;
        total++;
        if (out_ts_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_fall got=%b want=0", tag, out_ts_busy);
        end
        total++;
        if (rden_pulses - r0 != 1 || wr_pulses - w0 != 1) begin
            bad++;
            $display("FAIL %s pulses got rden=%0d wr=%0d want 1 1", tag,
                     rden_pulses - r0, wr_pulses - w0);
        end
`ifdef TS_STAT_EN
        total++;
        if (out_ts_q_cnt !== {mcnt[3], mcnt[2], mcnt[1], mcnt[0]}) begin
            bad++;
            $display("FAIL %s cnt got=%h want=%h", tag, out_ts_q_cnt,
                     {mcnt[3], mcnt[2], mcnt[1], mcnt[0]});
        end
`endif
    endtask

    function automatic logic [3:0][31:0] rand_md();
        logic [3:0][31:0] m;
        for (int i = 0; i < 4; i++) m[i] = $urandom;
        return m;
    endfunction

    task automatic test_reset;
        int r0;
        for (int i = 0; i < 4; i++) mcnt[i] = '0;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        total++;
        if (out_ts_q_rden !== 4'b0 || out_ts_q2_rden !== 1'b0 ||
            out_ts_md !== 32'b0 || out_ts_md_qid !== 2'b0 ||
            out_ts_md_discard !== 1'b0 || out_ts_md_wr !== 1'b0 ||
            out_ts_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got rden=%b md=%h qid=%0d d=%b wr=%b busy=%b want all 0",
                     out_ts_q_rden, out_ts_md, out_ts_md_qid,
                     out_ts_md_discard, out_ts_md_wr, out_ts_busy);
        end
`ifdef TS_STAT_EN
        total++;
        if (out_ts_q_cnt !== 128'b0) begin
            bad++;
            $display("FAIL reset_cnt got=%h want=0", out_ts_q_cnt);
        end
`endif
        r0 = rden_pulses;
        repeat (4) tick;
        total++;
        if (rden_pulses != r0 || out_ts_busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_empty_mask got rden=%0d busy=%b want 0 0",
                     rden_pulses - r0, out_ts_busy);
        end
    endtask

    task automatic test_basic;
        logic [3:0][31:0] m;
        m = rand_md();
        m[0] = 32'hA5A5_0040;
        run_pkt(4'b0001, m, 1'b0, 2, 1'b0, "basic_q0");
    endtask

    task automatic test_priority;
        run_pkt(4'b1110, rand_md(), 1'b0, 0, 1'b0, "prio_1110");
        run_pkt(4'b1100, rand_md(), 1'b1, 1, 1'b0, "prio_1100");
        run_pkt(4'b1111, rand_md(), 1'b1, 0, 1'b0, "prio_1111");
    endtask

    task automatic test_discard;
        run_pkt(4'b0100, rand_md(), 1'b1, 1, 1'b0, "discard_q2");
        run_pkt(4'b1000, rand_md(), 1'b1, 0, 1'b0, "discard_q3_ign");
    endtask

    task automatic test_ignore;
        run_pkt(4'b0010, rand_md(), 1'b0, 3, 1'b1, "ignore_noise");
    endtask

    task automatic test_back_to_back;
        run_pkt(4'b0100, rand_md(), 1'b0, 0, 1'b0, "b2b_a");
        run_pkt(4'b0001, rand_md(), 1'b0, 0, 1'b0, "b2b_b");
    endtask

    task automatic test_rst_in_cap;
        int r0;
        int w0;
        r0 = rden_pulses;
        w0 = wr_pulses;
        in_ts_q_md = rand_md();
        in_ts_schedule_valid = 4'b0001;
        tick;
        in_ts_schedule_valid = '0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mcnt[i] = '0;
        total++;
        if (out_ts_q_rden !== 4'b0 || out_ts_md !== 32'b0 ||
            out_ts_md_qid !== 2'b0 || out_ts_md_discard !== 1'b0 ||
            out_ts_md_wr !== 1'b0 || out_ts_busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_cap_outputs got rden=%b md=%h qid=%0d d=%b wr=%b busy=%b want all 0",
                     out_ts_q_rden, out_ts_md, out_ts_md_qid,
                     out_ts_md_discard, out_ts_md_wr, out_ts_busy);
        end
        tick;
        tick;
        total++;
        if (rden_pulses - r0 != 1 || wr_pulses != w0) begin
            bad++;
            $display("FAIL rst_cap_abandon got rden=%0d wr=%0d want 1 0",
                     rden_pulses - r0, wr_pulses - w0);
        end
        run_pkt(4'b1000, rand_md(), 1'b0, 1, 1'b0, "rst_cap_after");
    endtask

`ifdef TS_STAT_EN
    task automatic test_cnt_wrap;
        force u_dut.u_stat.cnt_q = {32'hFFFF_FFFF, mcnt[2], mcnt[1], mcnt[0]};
        tick;
        release u_dut.u_stat.cnt_q;
        mcnt[3] = 32'hFFFF_FFFF;
        run_pkt(4'b1000, rand_md(), 1'b0, 0, 1'b0, "cnt_wrap");
        total++;
        if (out_ts_q_cnt[127:96] !== 32'h0) begin
            bad++;
            $display("FAIL cnt_wrap_q3 got=%h want=0", out_ts_q_cnt[127:96]);
        end
    endtask
`endif

    task automatic test_random;
        logic [3:0] mask;
        for (int n = 0; n < 40; n++) begin
            mask = 4'($urandom_range(1, 15));
            run_pkt(mask, rand_md(), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    "random");
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_priority;
        test_discard;
        test_ignore;
        test_back_to_back;
        test_rst_in_cap;
`ifdef TS_STAT_EN
        test_cnt_wrap;
`endif
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
